// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - two-requester round-robin front end for one shared combinational adder.
// Optional ADDER_ARB_CHECK_EN adds an internal sum check driving the sticky chk_err flag.
module adder_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_cin,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_cin,
  input  logic [N-1:0] add_s,
  input  logic         add_cout,
  input  logic         add_prop,
  input  logic         add_gen,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_s,
  output logic         rsp_cout,
  output logic         rsp_prop,
  output logic         rsp_gen,
  output logic         chk_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t state;
  logic   last_grant;
  logic   grant_id;
  logic   accept;

  // With both requests pending the one not served last wins; a lone request always wins.
  always_comb begin
    grant_id = req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant_id;
  assign req1_ready = (state == IDLE) && req1_valid && grant_id;
  assign accept     = req0_ready || req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      add_a      <= '0;
      add_b      <= '0;
      add_cin    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_s      <= '0;
      rsp_cout   <= 1'b0;
      rsp_prop   <= 1'b0;
      rsp_gen    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Adder operands only move here so the shared adder sees no idle toggling.
          if (accept) begin
            add_a      <= grant_id ? req1_a   : req0_a;
            add_b      <= grant_id ? req1_b   : req0_b;
            add_cin    <= grant_id ? req1_cin : req0_cin;
            rsp_id     <= grant_id;
            last_grant <= grant_id;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_s     <= add_s;
          rsp_cout  <= add_cout;
          rsp_prop  <= add_prop;
          rsp_gen   <= add_gen;
          rsp_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDER_ARB_CHECK_EN
  logic [N:0] chk_sum;

  assign chk_sum = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (state == ISSUE && chk_sum != {add_cout, add_s}) begin
      chk_err <= 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed scoreboard bench for adder_arbiter with a behavioural shared adder.
module tb_adder_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] s;
    logic        cout;
    logic        prop;
    logic        gen;
  } rsp_t;

`ifdef ADDER_ARB_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [31:0] req1_a, req1_b;
  logic [31:0] add_a, add_b, add_s;
  logic        add_cin, add_cout, add_prop, add_gen;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_prop, rsp_gen;
  logic [31:0] rsp_s;
  logic        chk_err;

  logic        bad;
  logic        m_last;
  rsp_t        adder_r;
  rsp_t        last_e;
  rsp_t        sb[$];
  int          passed = 0;
  int          total = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout), .add_prop(add_prop), .add_gen(add_gen),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s),
    .rsp_cout(rsp_cout), .rsp_prop(rsp_prop), .rsp_gen(rsp_gen), .chk_err(chk_err)
  );

  function automatic rsp_t model(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic force_bad);
    rsp_t r;
    logic [32:0] sum;
    logic [32:0] sum_nc;
    sum    = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    sum_nc = {1'b0, a} + {1'b0, b};
    r.id   = 1'b0;
    r.s    = force_bad ? 32'h0000_1234 : sum[31:0];
    r.cout = sum[32];
    r.prop = &(a ^ b);
    r.gen  = sum_nc[32];
    return r;
  endfunction

  // Shared external adder, optionally corrupted to exercise the sum check.
  always_comb adder_r = model(add_a, add_b, add_cin, bad);
  assign add_s    = adder_r.s;
  assign add_cout = adder_r.cout;
  assign add_prop = adder_r.prop;
  assign add_gen  = adder_r.gen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic c0,
                    input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic c1,
                    input logic busy_issue);
    logic g;
    rsp_t e;
    rsp_t got;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
    #1;
    g = (v0 && v1) ? ~m_last : v1;
    check("req0_ready_idle", req0_ready, v0 && !g);
    check("req1_ready_idle", req1_ready, v1 && g);
    e = g ? model(a1, b1, c1, bad) : model(a0, b0, c0, bad);
    e.id = g;
    sb.push_back(e);
    m_last = g;
    step();
    if (!busy_issue) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    rsp_ready = busy_issue;
    #1;
    check("add_a_loaded", add_a, g ? a1 : a0);
    check("rsp_valid_issue", rsp_valid, 1'b0);
    if (busy_issue) begin
      check("req0_ready_issue", req0_ready, 1'b0);
      check("req1_ready_issue", req1_ready, 1'b0);
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    #1;
    check("rsp_valid_latency", rsp_valid, 1'b1);
    check("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      got = sb.pop_front();
      check("rsp_id", rsp_id, got.id);
      check("rsp_s", rsp_s, got.s);
      check("rsp_cout", rsp_cout, got.cout);
      check("rsp_prop", rsp_prop, got.prop);
      check("rsp_gen", rsp_gen, got.gen);
      last_e = got;
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_valid_released", rsp_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_last = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; bad = 1'b0; m_last = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    repeat (2) step();
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_add_a", add_a, 32'h0);
    check("rst_add_b", add_b, 32'h0);
    check("rst_add_cin", add_cin, 1'b0);
    check("rst_rsp_s", rsp_s, 32'h0);
    check("rst_rsp_flags", {rsp_id, rsp_cout, rsp_prop, rsp_gen}, 4'b0);
    check("rst_chk_err", chk_err, 1'b0);
    check("rst_ready", {req0_ready, req1_ready}, 2'b00);
    rst_n = 1'b1;

    // Single request with carry out of the top bit.
    op(1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("t1_s", rsp_s, 32'h0);
    check("t1_cout", rsp_cout, 1'b1);
    check("t1_id", rsp_id, 1'b0);
    release_rsp();
    repeat (2) step();
    check("t1_add_a_held", add_a, 32'h0000_0001);
    check("t1_add_b_held", add_b, 32'hFFFF_FFFF);

    // Both requesters valid: strict alternation starting at req0 after reset.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      op(1'b1, 32'h100 + k, 32'h10 * k, k[0], 1'b1, 32'hA000_0000 + k, 32'h6000_0000, ~k[0], k == 3);
      check("rr_id", rsp_id, k[0]);
      release_rsp();
    end

    // Lone req1 wins even though it was served last; response held for 5 cycles.
    op(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    check("hold_id", rsp_id, 1'b1);
    for (int i = 0; i < 5; i++) begin
      req0_valid = (i == 1);
      req0_a = 32'hDEAD_BEEF;
      #1;
      check("hold_req0_ready", req0_ready, 1'b0);
      check("hold_rsp_valid", rsp_valid, 1'b1);
      check("hold_rsp_s", rsp_s, last_e.s);
      check("hold_rsp_cout", rsp_cout, last_e.cout);
      step();
    end
    req0_valid = 1'b0;
    release_rsp();
    repeat (3) step();
    check("dropped_no_rsp", rsp_valid, 1'b0);
    check("dropped_add_a", add_a, 32'h7FFF_FFFF);
    check("dropped_sb_empty", sb.size(), 0);

    // Reset while holding a response discards it at once.
    op(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5, 32'h6, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_add_a", add_a, 32'h0);
    check("midrst_rsp_s", rsp_s, 32'h0);
    step();
    rst_n = 1'b1;
    m_last = 1'b1;
    op(1'b1, 32'h22, 32'h33, 1'b1, 1'b1, 32'h44, 32'h55, 1'b0, 1'b0);
    check("postrst_id", rsp_id, 1'b0);
    release_rsp();

    // Corrupted adder result: flagged only when the check is built in, and sticky.
    bad = 1'b1;
    op(1'b1, 32'h1, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    bad = 1'b0;
    check("bad_rsp_s", rsp_s, 32'h0000_1234);
    check("chk_err_set", chk_err, CHK);
    release_rsp();
    op(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3, 32'h4, 1'b0, 1'b0);
    release_rsp();
    check("chk_err_sticky", chk_err, CHK);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, giving the operand and sum width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports req0_valid, input, 1 bit, and req0_ready, output, 1 bit: requester 0 handshake.
REQ-005 SHALL have ports req0_a and req0_b, input, N bits each, and req0_cin, input, 1 bit: requester 0 operands.
REQ-006 SHALL have ports req1_valid, req1_ready, req1_a, req1_b and req1_cin: requester 1, with the same directions and widths as requester 0.
REQ-007 SHALL have ports add_a and add_b, output, N bits each, and add_cin, output, 1 bit: registered operands driven to the shared external combinational adder.
REQ-008 SHALL have ports add_s, input, N bits, and add_cout, add_prop and add_gen, input, 1 bit each: results returned by the shared adder.
REQ-009 SHALL have ports rsp_valid, output, 1 bit, and rsp_ready, input, 1 bit: response handshake.
REQ-010 SHALL have ports rsp_id, output, 1 bit, rsp_s, output, N bits, and rsp_cout, rsp_prop and rsp_gen, output, 1 bit each: the granted requester index and the registered results.
REQ-011 SHALL have port chk_err, output, 1 bit: sticky adder-mismatch flag.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, ISSUE and HOLD.
REQ-013 SHALL, in IDLE, assert reqX_ready combinationally only for the granted requester X; ready SHALL be 0 outside IDLE.
REQ-014 SHALL, when both requests are valid, grant the requester not granted last (round-robin); a single valid request SHALL always be granted.
REQ-015 SHALL, on the accepting edge (valid and ready both high), load add_a, add_b and add_cin from the granted requester, record rsp_id, update last_grant and enter ISSUE.
REQ-016 SHALL, in ISSUE, capture add_s, add_cout, add_prop and add_gen into the rsp_* registers on the next edge, set rsp_valid and enter HOLD.
REQ-017 SHALL, in HOLD, keep rsp_valid and all rsp_* values stable until rsp_ready is high; on the edge where rsp_ready is high it SHALL clear rsp_valid and enter IDLE.
REQ-018 SHALL give a latency of 2 edges from accept to rsp_valid, and a best-case throughput of one operation per 3 cycles.
REQ-019 SHALL hold add_a, add_b and add_cin at their last values outside the accepting edge, to minimise switching activity at the shared adder.
REQ-020 SHALL ignore requests and rsp_ready held high while the FSM is in ISSUE; no accept SHALL occur outside IDLE.
REQ-021 SHALL ignore a valid request dropped before it is accepted; such a request SHALL leave no state behind.

Reset
REQ-022 SHALL, while rst_n is low, force state IDLE, add_a, add_b and add_cin to 0, all rsp_* outputs to 0, rsp_valid to 0, chk_err to 0 and last_grant to 1, so that requester 0 wins first.
REQ-023 SHALL, when rst_n is asserted mid-operation in ISSUE or HOLD, discard the in-flight result immediately, with no response issued.

Configuration
REQ-024 SHALL, with macro ADDER_ARB_CHECK_EN defined, compute {add_cout, add_s} internally as add_a + add_b + add_cin at the ISSUE capture edge and set chk_err on mismatch; chk_err SHALL stay set until reset.
REQ-025 SHALL, without ADDER_ARB_CHECK_EN, keep the chk_err port present but tie it to 0 and include no check logic.

Verification
REQ-026 Single request: req0 with a=0x0000_0001, b=0xFFFF_FFFF, cin=0 -> accepted; rsp_valid 2 edges later with rsp_s=0, rsp_cout=1, rsp_id=0.
REQ-027 Both requesters valid continuously -> grants alternate 0,1,0,1 across 4 operations; first grant after reset goes to req0.
REQ-028 rsp_ready held low 5 cycles -> rsp_* stable, req ready stays 0; rsp_ready high -> returns to IDLE on the next edge.
REQ-029 rst_n pulsed low during HOLD -> rsp_valid=0 and add_a=0 immediately; the next request after release goes to req0.
REQ-030 With ADDER_ARB_CHECK_EN, adder model forces add_s=0x1234 for a=1, b=1, cin=0 -> chk_err=1 and stays set; without the macro chk_err stays 0.
REQ-031 Request valid for 1 cycle while the FSM is in HOLD, then dropped -> no accept occurs and no extra response is issued.
